// File: rtl/endpoint_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// endpoint_mmio_ctrl
//
// Host-facing memory-mapped control block for the chiplet endpoint. It holds:
//   - one packet start-address register per message slot,
//   - a FIFO of send requests toward the TX FSM,
//   - a round-robin arbiter for the single TX cache port, shared by the host
//     bus and the TX FSM. A stalled access keeps ownership until it completes.
//
// Host address map:
//   0x0000 + 4*i : start-address register for slot i (read/write)
//   0x1004       : SEND (write-only, enqueues a message ID)
//   0x1008       : STATUS {count[15:8], 6'b0, full, empty} (read-only)
//   0x100C       : drop counter (only when ENDPOINT_SEND_DROP_EN is defined)
//   0x2000 + ... : TX cache window, CACHE_NUM_WORDS*4 bytes
//
// Optional feature macro: ENDPOINT_SEND_DROP_EN
//   Defined     : a SEND write while the queue is full (and nothing pops in
//                 that cycle) is dropped with host_error=1. A saturating 8-bit
//                 drop counter counts these writes. It reads at 0x100C, and any
//                 write to 0x100C clears it.
//   Not defined : a SEND write while the queue is full stalls the host, and
//                 0x100C is unmapped.
//
// Ports:
//   clk, n_rst                          clock, asynchronous active-low reset
//   host_ren/wen/addr/wdata/strobe      host bus request
//   host_rdata/error/stall              host bus response
//   tx_ren/wen/addr                     TX FSM cache request
//   tx_rdata/stall                      TX FSM cache response
//   cache_ren/wen/addr/wdata/strobe     TX cache request (arbitrated)
//   cache_rdata/stall                   TX cache response
//   pkt_start_addr                      flattened start-address table
//   send_valid/send_id/send_ready       send-queue head handshake
// -----------------------------------------------------------------------------
module endpoint_mmio_ctrl #(
    parameter int NUM_MSGS        = 4,
    parameter int CACHE_NUM_WORDS = 128,
    parameter int SEND_Q_DEPTH    = 4,
    localparam int CA             = $clog2(CACHE_NUM_WORDS) + 2,
    localparam int IDW            = $clog2(NUM_MSGS)
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   host_ren,
    input  logic                   host_wen,
    input  logic [31:0]            host_addr,
    input  logic [31:0]            host_wdata,
    input  logic [3:0]             host_strobe,
    output logic [31:0]            host_rdata,
    output logic                   host_error,
    output logic                   host_stall,
    input  logic                   tx_ren,
    input  logic                   tx_wen,
    input  logic [CA-1:0]          tx_addr,
    output logic [31:0]            tx_rdata,
    output logic                   tx_stall,
    output logic                   cache_ren,
    output logic                   cache_wen,
    output logic [CA-1:0]          cache_addr,
    output logic [31:0]            cache_wdata,
    output logic [3:0]             cache_strobe,
    input  logic [31:0]            cache_rdata,
    input  logic                   cache_stall,
    output logic [NUM_MSGS*CA-1:0] pkt_start_addr,
    output logic                   send_valid,
    output logic [IDW-1:0]         send_id,
    input  logic                   send_ready
);

    localparam int QAW = $clog2(SEND_Q_DEPTH);
    localparam int CW  = QAW + 1;

    localparam logic [31:0] BAD_DATA    = 32'hBAD1_BAD1;
    localparam logic [31:0] SLOT_BYTES  = 32'(NUM_MSGS * 4);
    localparam logic [31:0] SEND_ADDR   = 32'h0000_1004;
    localparam logic [31:0] STATUS_ADDR = 32'h0000_1008;
    localparam logic [31:0] CACHE_BASE  = 32'h0000_2000;
    localparam logic [31:0] CACHE_BYTES = 32'(CACHE_NUM_WORDS * 4);
`ifdef ENDPOINT_SEND_DROP_EN
    localparam logic [31:0] DROP_ADDR   = 32'h0000_100C;
`endif

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_TX   = 2'd2
    } owner_e;

    typedef enum logic {
        PRIO_HOST = 1'b0,
        PRIO_TX   = 1'b1
    } prio_e;

    // State
    logic [CA-1:0]  start_addr_r [NUM_MSGS];
    logic [IDW-1:0] q_mem_r      [SEND_Q_DEPTH];
    logic [QAW-1:0] wr_ptr_r;
    logic [QAW-1:0] rd_ptr_r;
    logic [CW-1:0]  q_count_r;
    owner_e         owner_r;
    prio_e          prio_r;
`ifdef ENDPOINT_SEND_DROP_EN
    logic [7:0]     drop_cnt_r;
`endif

    // Decode and control signals
    logic           host_req_s;
    logic           is_slot_s;
    logic           is_send_s;
    logic           is_status_s;
    logic           is_cache_s;
    logic [IDW-1:0] slot_idx_s;
    logic           host_cache_req_s;
    logic           tx_req_s;
    logic           q_full_s;
    logic           q_empty_s;
    logic           pop_s;
    logic           send_wr_s;
    logic           send_id_ok_s;
    logic           push_s;
    logic [31:0]    status_s;
    logic           grant_host_s;
    logic           grant_tx_s;
    logic           owner_drop_s;
`ifdef ENDPOINT_SEND_DROP_EN
    logic           is_drop_s;
    logic           drop_s;
`endif

    // ------------------------------------------------------------------
    // Address decode and send-queue handshake
    // ------------------------------------------------------------------
    assign host_req_s       = host_ren | host_wen;
    assign is_slot_s        = (host_addr < SLOT_BYTES);
    assign is_send_s        = (host_addr == SEND_ADDR);
    assign is_status_s      = (host_addr == STATUS_ADDR);
    assign is_cache_s       = (host_addr >= CACHE_BASE) &&
                              ((host_addr - CACHE_BASE) < CACHE_BYTES);
    assign slot_idx_s       = host_addr[2 +: IDW];
    assign host_cache_req_s = host_req_s & is_cache_s;
    assign tx_req_s         = tx_ren | tx_wen;

    assign q_full_s     = (q_count_r == CW'(SEND_Q_DEPTH));
    assign q_empty_s    = (q_count_r == CW'(0));
    assign pop_s        = send_valid & send_ready;
    assign send_wr_s    = host_wen & ~host_ren & is_send_s;
    assign send_id_ok_s = (host_wdata < 32'(NUM_MSGS));
    // A full queue still accepts the push when the head pops in the same cycle.
    assign push_s       = send_wr_s & send_id_ok_s & (~q_full_s | pop_s);
`ifdef ENDPOINT_SEND_DROP_EN
    assign is_drop_s    = (host_addr == DROP_ADDR);
    assign drop_s       = send_wr_s & send_id_ok_s & q_full_s & ~pop_s;
`endif

    assign status_s   = {16'h0000, 8'(q_count_r), 6'b00_0000, q_full_s, q_empty_s};
    assign send_valid = ~q_empty_s;
    assign send_id    = q_empty_s ? IDW'(0) : q_mem_r[rd_ptr_r];

    // Flatten the start-address table onto the output bus.
    always_comb begin
        pkt_start_addr = '0;
        for (int i = 0; i < NUM_MSGS; i++) begin
            pkt_start_addr[i*CA +: CA] = start_addr_r[i];
        end
    end

    // ------------------------------------------------------------------
    // Cache arbiter: pick the grant for this cycle
    // ------------------------------------------------------------------
    // A locked owner keeps the grant. If it drops its request, nobody is
    // granted that cycle and the lock is released at the next edge.
    always_comb begin
        grant_host_s = 1'b0;
        grant_tx_s   = 1'b0;
        owner_drop_s = 1'b0;
        case (owner_r)
            OWN_HOST: begin
                if (host_cache_req_s) begin
                    grant_host_s = 1'b1;
                end else begin
                    owner_drop_s = 1'b1;
                end
            end
            OWN_TX: begin
                if (tx_req_s) begin
                    grant_tx_s = 1'b1;
                end else begin
                    owner_drop_s = 1'b1;
                end
            end
            OWN_NONE: begin
                if (host_cache_req_s && tx_req_s) begin
                    if (prio_r == PRIO_HOST) begin
                        grant_host_s = 1'b1;
                    end else begin
                        grant_tx_s = 1'b1;
                    end
                end else if (host_cache_req_s) begin
                    grant_host_s = 1'b1;
                end else if (tx_req_s) begin
                    grant_tx_s = 1'b1;
                end else begin
                    grant_host_s = 1'b0;
                    grant_tx_s   = 1'b0;
                end
            end
            default: begin
                owner_drop_s = 1'b1;
            end
        endcase
    end

    // Drive the cache port from whichever requester holds the grant.
    // The TX FSM has no write-data path, so a TX write carries zero data
    // with no byte lanes enabled.
    always_comb begin
        cache_ren    = 1'b0;
        cache_wen    = 1'b0;
        cache_addr   = '0;
        cache_wdata  = 32'h0000_0000;
        cache_strobe = 4'h0;
        if (grant_host_s) begin
            cache_ren    = host_ren;
            cache_wen    = host_wen;
            cache_addr   = host_addr[CA-1:0];
            cache_wdata  = host_wdata;
            cache_strobe = host_strobe;
        end else if (grant_tx_s) begin
            cache_ren    = tx_ren;
            cache_wen    = tx_wen;
            cache_addr   = tx_addr;
            cache_wdata  = 32'h0000_0000;
            cache_strobe = 4'h0;
        end else begin
            cache_ren    = 1'b0;
            cache_wen    = 1'b0;
        end
    end

    // Response to the TX FSM. A TX request that is not granted sees a stall.
    always_comb begin
        tx_rdata = BAD_DATA;
        tx_stall = 1'b0;
        if (grant_tx_s) begin
            tx_rdata = cache_rdata;
            tx_stall = cache_stall;
        end else if (tx_req_s) begin
            tx_stall = 1'b1;
        end else begin
            tx_rdata = BAD_DATA;
            tx_stall = 1'b0;
        end
    end

    // Response to the host for every region of the address map.
    always_comb begin
        host_rdata = BAD_DATA;
        host_error = 1'b0;
        host_stall = 1'b0;
        if (!host_req_s) begin
            host_rdata = BAD_DATA;
        end else if (is_slot_s) begin
            if (host_ren) begin
                host_rdata = 32'(start_addr_r[slot_idx_s]);
            end else begin
                host_rdata = BAD_DATA;
            end
        end else if (is_send_s) begin
            if (host_ren) begin
                host_error = 1'b1;
            end else if (!send_id_ok_s) begin
                host_error = 1'b1;
            end else if (q_full_s && !pop_s) begin
`ifdef ENDPOINT_SEND_DROP_EN
                host_error = 1'b1;
`else
                host_stall = 1'b1;
`endif
            end else begin
                host_error = 1'b0;
            end
        end else if (is_status_s) begin
            if (host_wen) begin
                host_error = 1'b1;
            end else begin
                host_rdata = status_s;
            end
`ifdef ENDPOINT_SEND_DROP_EN
        end else if (is_drop_s) begin
            if (host_ren) begin
                host_rdata = {24'h00_0000, drop_cnt_r};
            end else begin
                host_rdata = BAD_DATA;
            end
`endif
        end else if (is_cache_s) begin
            if (grant_host_s) begin
                host_rdata = cache_rdata;
                host_stall = cache_stall;
            end else begin
                host_stall = 1'b1;
            end
        end else begin
            host_error = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Start-address registers. Writes are forced to word alignment.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_MSGS; i++) begin
                start_addr_r[i] <= '0;
            end
        end else if (host_wen && !host_ren && is_slot_s) begin
            start_addr_r[slot_idx_s] <= {host_wdata[CA-1:2], 2'b00};
        end else begin
            start_addr_r <= start_addr_r;
        end
    end

    // Send-request FIFO: storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < SEND_Q_DEPTH; i++) begin
                q_mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            q_count_r <= '0;
        end else begin
            if (push_s) begin
                q_mem_r[wr_ptr_r] <= host_wdata[IDW-1:0];
                wr_ptr_r          <= wr_ptr_r + QAW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + QAW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   q_count_r <= q_count_r + CW'(1);
                2'b01:   q_count_r <= q_count_r - CW'(1);
                default: q_count_r <= q_count_r;
            endcase
        end
    end

    // Arbiter lock and round-robin priority.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            owner_r <= OWN_NONE;
            prio_r  <= PRIO_HOST;
        end else if (grant_host_s || grant_tx_s) begin
            if (cache_stall) begin
                owner_r <= grant_host_s ? OWN_HOST : OWN_TX;
            end else begin
                // On completion, the requester that did not win gets priority.
                owner_r <= OWN_NONE;
                prio_r  <= grant_host_s ? PRIO_TX : PRIO_HOST;
            end
        end else if (owner_drop_s) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= owner_r;
        end
    end

`ifdef ENDPOINT_SEND_DROP_EN
    // Saturating count of SEND writes dropped on a full queue.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            drop_cnt_r <= 8'h00;
        end else if (host_wen && !host_ren && is_drop_s) begin
            drop_cnt_r <= 8'h00;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'h01;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end
`endif

endmodule
